instr_fetch: RTL
================

# instr_fetch

Instruction fetch stage sitting directly downstream of the program counter. Takes the PC's registered address, issues a synchronous read to instruction memory and holds the returned word for the decoder behind a valid/ready handshake. It also drives the PC's `inc` and `current_addr` inputs so the PC advances exactly once per fetched instruction, and it discards in-flight or held instructions when execute signals a taken branch.

## Interface
- `ADDR_W`, default 11: instruction address width; must match the PC.
- `INSTR_W`, default 16: instruction word width.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `pc_addr`  in  ADDR_W: address of the next instruction; driven by the PC `next_addr`.
- `branch_flush`  in  1: taken branch this cycle; the PC loads its target on the same edge.
- `pc_inc`  out  1: to the PC `inc`.
- `pc_cur_addr`  out  ADDR_W: to the PC `current_addr`.
- `imem_en`  out  1: instruction memory read enable.
- `imem_addr`  out  ADDR_W: instruction memory read address.
- `imem_rdata`  in  INSTR_W: read data, valid in the cycle after `imem_en`.
- `instr_valid`  out  1: `instr` and `instr_pc` are valid.
- `instr_ready`  in  1: decoder accepts the held instruction.
- `instr`  out  INSTR_W: held instruction word.
- `instr_pc`  out  ADDR_W: address the held instruction was fetched from.

## Operation
- The FSM has four states: IDLE, FETCH, WAIT and HOLD. Reset forces IDLE.
- **IDLE:** all strobes are low. Unconditionally go to FETCH on the next cycle.
- **FETCH:**
  - Drive `imem_en`=1 and `imem_addr`=`pc_addr`.
  - Register `req_addr` <= `pc_addr`.
  - Go to WAIT. If `branch_flush`=1, also set `discard` <= 1.
- **WAIT:** `imem_rdata` is valid this cycle.
  - If `discard`=0 and `branch_flush`=0:
    - `instr` <= `imem_rdata`, `instr_pc` <= `req_addr`, `instr_valid` <= 1.
    - Drive `pc_inc`=1 and `pc_cur_addr`=`req_addr` combinationally.
    - Go to HOLD.
  - Otherwise: do not capture, `pc_inc`=0, clear `discard`, go to FETCH.
- **HOLD:** `instr_valid`=1, and the outputs stay stable until the handshake completes.
  - `instr_valid` & `instr_ready` & !`branch_flush`: transfer; `instr_valid` <= 0, go to FETCH.
  - `branch_flush`=1: drop the instruction even if `instr_ready`=1 in the same cycle. No transfer counts. `instr_valid` <= 0, go to FETCH.
- `pc_cur_addr` equals `req_addr` at all times. `pc_inc` is high only in WAIT when the capture condition holds.
- Address arithmetic lives in the PC. The PC wraps 0x7FF+1 to 0x000, and this block passes addresses through unchanged.

## Timing
- **Reset values:** `pc_inc`=0, `pc_cur_addr`=0, `imem_en`=0, `imem_addr`=`pc_addr` (combinational), `instr_valid`=0, `instr`=0, `instr_pc`=0, `discard`=0, state IDLE.
- **Throughput:** with `instr_ready` tied high, the cycle after IDLE is FETCH, then WAIT, then HOLD, then FETCH again. That gives one instruction per 3 cycles.
- **Latency:** from FETCH to `instr_valid`=1 is 2 cycles.
- **PC update:** the PC updates on the edge ending WAIT. In HOLD, `pc_addr` = `instr_pc`+1.
- **Flush in WAIT:** the PC's branch priority and the suppressed `pc_inc` mean the edge leaves the PC at the target. The next FETCH reads the target.
- **Flush in FETCH:** the memory read is issued but discarded. FETCH for the target follows 2 cycles later.
- **Reset mid-operation:** reset in any state returns to IDLE on the next edge. Any held or in-flight instruction is lost and `pc_inc` is not pulsed.

## Configuration
- `FETCH_PERF_CNT_EN` defined: adds two output ports.
  - `perf_fetched` (16 bits): counts completed handshakes.
  - `perf_flushed` (16 bits): counts WAIT/HOLD cycles that drop an instruction because of `branch_flush`.
  - Both counters saturate at 0xFFFF and clear on `rst`.
- `FETCH_PERF_CNT_EN` undefined: the ports and counters are absent, and functional behaviour is identical.

## Test plan
- **Reset then stream:** deassert `rst`, `instr_ready`=1, memory word = address XOR 0xA5A5.
  - `instr_valid` first rises 3 cycles after reset release, with `instr_pc`=0x000 and `instr`=0xA5A5.
  - Subsequent `instr_pc` values are 1, 2, 3 at 3-cycle spacing.
- **Backpressure:** hold `instr_ready`=0 for 5 cycles while in HOLD at 0x004.
  - `instr`, `instr_pc` and `instr_valid` stay stable.
  - `pc_inc` does not pulse again and `imem_en` stays 0.
  - Releasing `instr_ready` transfers exactly once.
- **Flush in HOLD with ready:** `branch_flush`=1 and `instr_ready`=1 together, PC target 0x100.
  - The instruction is not transferred (perf_fetched unchanged).
  - The next `instr_pc` is 0x100.
- **Flush in FETCH and in WAIT:** apply each case separately, target 0x0F0.
  - No `pc_inc` pulse occurs for the discarded read.
  - The next valid `instr_pc` is 0x0F0.
- **Wrap-around:** start from 0x7FE. Delivered `instr_pc` values are 0x7FE, 0x7FF, 0x000.
- **Reset mid-operation:** assert `rst` in WAIT.
  - `instr_valid` stays 0 and `pc_inc` stays 0 that cycle.
  - After release, fetch restarts from 0x000.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues synchronous imem reads at the PC address, holds the word
// for the decoder behind valid/ready and advances the PC once per capture. Option: FETCH_PERF_CNT_EN.
module instr_fetch #(
    parameter int ADDR_W  = 11,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  pc_addr,
    input  logic               branch_flush,
    output logic               pc_inc,
    output logic [ADDR_W-1:0]  pc_cur_addr,
    output logic               imem_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]        perf_fetched,
    output logic [15:0]        perf_flushed
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] req_addr;
    logic              discard;
    logic              capture;
    logic              transfer;
    logic              drop;

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        transfer  = 1'b0;
        drop      = 1'b0;
        case (state)
            S_IDLE:  state_nxt = S_FETCH;
            S_FETCH: state_nxt = S_WAIT;
            S_WAIT: begin
                capture   = !discard && !branch_flush;
                drop      = !discard && branch_flush;
                state_nxt = capture ? S_HOLD : S_FETCH;
            end
            S_HOLD: begin
                // A flush wins over a simultaneous ready: the held word is dropped, not transferred.
                if (branch_flush) begin
                    drop      = 1'b1;
                    state_nxt = S_FETCH;
                end else if (instr_ready) begin
                    transfer  = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Reset masks the increment so a reset during WAIT never advances the PC.
    assign pc_inc      = capture && !rst;
    assign pc_cur_addr = req_addr;
    assign imem_en     = (state == S_FETCH);
    assign imem_addr   = pc_addr;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            req_addr    <= '0;
            discard     <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_FETCH) begin
                req_addr <= pc_addr;
                discard  <= branch_flush;
            end
            if (state == S_WAIT) begin
                discard <= 1'b0;
            end
            if (capture) begin
                instr       <= imem_rdata;
                instr_pc    <= req_addr;
                instr_valid <= 1'b1;
            end
            if (transfer || (state == S_HOLD && drop)) begin
                instr_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            if (transfer && perf_fetched != 16'hFFFF) begin
                perf_fetched <= perf_fetched + 16'd1;
            end
            if (drop && perf_flushed != 16'hFFFF) begin
                perf_flushed <= perf_flushed + 16'd1;
            end
        end
    end
`endif

endmodule
